// File: rtl/pc_stack_if.sv
// Bus bundle between the decode controller (master) and the return-address stack (slave).
interface pc_stack_if #(
  parameter int DEPTH = 8,
  parameter int AW    = 12
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          push;
  logic          pop;
  logic [AW-1:0] pushData;
  logic          clearErr;
  logic [AW-1:0] topData;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  modport master (
    output push, pop, pushData, clearErr,
    input  topData, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, pushData, clearErr,
    output topData, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/pc_stack.sv
// Hardware return-address stack: call pushes PC+1, return presents the top for the PC mux
// and removes it at the same edge; misuse is latched in sticky overflow/underflow flags.
module pc_stack #(
  parameter int DEPTH = 8,
  parameter int AW    = 12
) (
  input  logic       clock,
  input  logic       init_signal,
  pc_stack_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  logic [CW-1:0] sp_q, sp_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [AW-1:0] mem_q [DEPTH];
  logic [AW-1:0] mem_d [DEPTH];

  logic          empty_s;
  logic          full_s;
  logic [IW-1:0] top_idx_s;
  logic [IW-1:0] wr_idx_s;
  logic          wr_en_s;

  assign empty_s   = (sp_q == CW'(0));
  assign full_s    = (sp_q == CW'(DEPTH));
  assign top_idx_s = IW'(sp_q - CW'(1));

  // Next-state decode of push/pop in priority order; a flag set beats clearErr.
  always_comb begin
    sp_d     = sp_q;
    ovf_d    = ovf_q & ~bus.clearErr;
    unf_d    = unf_q & ~bus.clearErr;
    wr_en_s  = 1'b0;
    wr_idx_s = {IW{1'b0}};
    if (bus.push && bus.pop && !empty_s) begin
      wr_en_s  = 1'b1;
      wr_idx_s = top_idx_s;
    end else if (bus.push && bus.pop) begin
      wr_en_s  = 1'b1;
      wr_idx_s = {IW{1'b0}};
      sp_d     = CW'(1);
    end else if (bus.push) begin
      if (!full_s) begin
        wr_en_s  = 1'b1;
        wr_idx_s = IW'(sp_q);
        sp_d     = sp_q + CW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end else if (bus.pop) begin
      if (!empty_s) begin
        sp_d = sp_q - CW'(1);
      end else begin
        unf_d = 1'b1;
      end
    end else begin
      sp_d = sp_q;
    end
  end

  // Storage write-back of the selected entry.
  always_comb begin
    mem_d = mem_q;
    if (wr_en_s) begin
      mem_d[wr_idx_s] = bus.pushData;
    end else begin
      mem_d[wr_idx_s] = mem_q[wr_idx_s];
    end
  end

  // Pointer and sticky flags, cleared asynchronously.
  always_ff @(posedge clock or negedge init_signal) begin
    if (!init_signal) begin
      sp_q  <= {CW{1'b0}};
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Entry array carries no reset; contents are invisible while the stack is empty.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign bus.topData   = empty_s ? {AW{1'b0}} : mem_q[top_idx_s];
  assign bus.count     = sp_q;
  assign bus.empty     = empty_s;
  assign bus.full      = full_s;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: vector table through a scoreboard queue plus reset sequences.
module tb_pc_stack;
  logic clock = 1'b0;
  logic init_signal = 1'b0;

  pc_stack_if #(.DEPTH(8), .AW(12)) bus ();

  pc_stack #(.DEPTH(8), .AW(12)) u_dut (
    .clock       (clock),
    .init_signal (init_signal),
    .bus         (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        push;
    logic        pop;
    logic        clr;
    logic [11:0] data;
    logic [11:0] top;
    logic [3:0]  cnt;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic p, input logic o, input logic c, input int d,
                     input int top, input int cnt, input logic ovf, input logic unf);
    vec_t v;
    v.push = p; v.pop = o; v.clr = c; v.data = 12'(d);
    v.top = 12'(top); v.cnt = 4'(cnt); v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endtask

  task automatic check_state(input string tag, input vec_t e);
    chk({tag, ".topData"},   32'(bus.topData),   32'(e.top));
    chk({tag, ".count"},     32'(bus.count),     32'(e.cnt));
    chk({tag, ".empty"},     32'(bus.empty),     32'(e.cnt == 4'd0));
    chk({tag, ".full"},      32'(bus.full),      32'(e.cnt == 4'd8));
    chk({tag, ".overflow"},  32'(bus.overflow),  32'(e.ovf));
    chk({tag, ".underflow"}, 32'(bus.underflow), 32'(e.unf));
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge clock);
    bus.push = v.push; bus.pop = v.pop; bus.clearErr = v.clr; bus.pushData = v.data;
    exp_q.push_back(v);
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_state($sformatf("vec%0d", idx), e);
    end
  endtask

  initial begin
    vec_t z;
    // LIFO order
    add(1'b1, 1'b0, 1'b0, 12'h010, 12'h010, 1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 12'h020, 12'h020, 2, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 12'h030, 12'h030, 3, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 12'h000, 12'h020, 2, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 12'h000, 12'h010, 1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 12'h000, 12'h000, 0, 1'b0, 1'b0);
    // fill, overflow, drain, clear
    for (int k = 0; k < 8; k++) add(1'b1, 1'b0, 1'b0, 12'h100 + k, 12'h100 + k, k + 1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 12'hFFF, 12'h107, 8, 1'b1, 1'b0);
    for (int k = 6; k >= 0; k--) add(1'b0, 1'b1, 1'b0, 12'h000, 12'h100 + k, k + 1, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 12'h000, 12'h000, 0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 12'h000, 12'h000, 0, 1'b0, 1'b0);
    // underflow, set-wins, clear
    add(1'b0, 1'b1, 1'b0, 12'h000, 12'h000, 0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 12'h000, 12'h000, 0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 12'h000, 12'h000, 0, 1'b0, 1'b0);
    // simultaneous push+pop
    add(1'b1, 1'b0, 1'b0, 12'h0AA, 12'h0AA, 1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 12'h0BB, 12'h0BB, 2, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 12'h0CC, 12'h0CC, 2, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 12'h000, 12'h0AA, 1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 12'h000, 12'h000, 0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 12'h055, 12'h055, 1, 1'b0, 1'b0);
    // pushes ahead of the mid-operation reset
    add(1'b1, 1'b0, 1'b0, 12'h011, 12'h011, 2, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 12'h022, 12'h022, 3, 1'b0, 1'b0);

    // reset held over two edges with a push strobed
    bus.push = 1'b1; bus.pop = 1'b0; bus.clearErr = 1'b0; bus.pushData = 12'h123;
    init_signal = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    z.top = 12'h000; z.cnt = 4'd0; z.ovf = 1'b0; z.unf = 1'b0;
    z.push = 1'b0; z.pop = 1'b0; z.clr = 1'b0; z.data = 12'h000;
    check_state("reset", z);
    @(negedge clock);
    bus.push = 1'b0;
    init_signal = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // asynchronous reset between edges, then a strobed push under reset is discarded
    @(negedge clock);
    bus.push = 1'b0; bus.pop = 1'b0; bus.clearErr = 1'b0;
    #1;
    init_signal = 1'b0;
    #1;
    check_state("async_rst", z);
    bus.push = 1'b1; bus.pushData = 12'h0EE;
    @(posedge clock);
    #1;
    check_state("rst_held", z);
    @(negedge clock);
    bus.push = 1'b0;
    init_signal = 1'b1;
    z.push = 1'b1; z.data = 12'h033; z.top = 12'h033; z.cnt = 4'd1;
    apply(z, 999);
    @(negedge clock);
    bus.push = 1'b0;

    if (exp_q.size() != 0) chk("scoreboard_leftover", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_stack.md
# pc_stack

Hardware return-address stack that services the `push`/`pop` strobes produced by the instruction-decode controller for call and return instructions. On a call it stores the return address supplied by the datapath. On a return it presents the most recently stored address on `topData` in the same cycle, so the PC input mux (select `2'b10`) can load it at the next clock edge, when the entry is removed. The block sits beside the PC register in the datapath, has one clock domain, and reports misuse through sticky overflow/underflow flags.

## Interface
- `DEPTH`, 8, number of stack entries (power of two, ≥ 2)
- `AW`, 12, address width; matches the 12-bit instruction address field

- `clock`  in  1  rising-edge clock
- `init_signal`  in  1  asynchronous, active-low reset
- `push`  in  1  store `pushData` at this edge (call instruction)
- `pop`  in  1  remove top entry at this edge (return instruction)
- `pushData`  in  AW  return address to store (PC+1 from datapath)
- `clearErr`  in  1  synchronous clear of `overflow`/`underflow`
- `topData`  out  AW  current top entry; 0 when empty
- `count`  out  $clog2(DEPTH+1)  number of valid entries
- `empty`  out  1  `count == 0`
- `full`  out  1  `count == DEPTH`
- `overflow`  out  1  sticky: a push was dropped because the stack was full
- `underflow`  out  1  sticky: a pop was attempted while the stack was empty

## Operation
- Storage is a DEPTH×AW register array plus a stack pointer `sp` (0..DEPTH) equal to `count`. Entries occupy `mem[0..sp-1]`; the top is `mem[sp-1]`.
- `topData` is combinational from registers: `mem[sp-1]` when `sp != 0`, else 0. It never depends combinationally on `push`, `pop` or `pushData`.
- Actions are evaluated at each rising edge, in priority order:
  - `push` & `pop` & !empty: replace the top (`mem[sp-1] <= pushData`); `sp` is unchanged; no flags change.
  - `push` & `pop` & empty: treated as push only (`mem[0] <= pushData`, `sp <= 1`); `underflow` is not set.
  - `push` only, !full: `mem[sp] <= pushData`, `sp <= sp+1`.
  - `push` only, full: no write, `sp` unchanged, `overflow <= 1`.
  - `pop` only, !empty: `sp <= sp-1`. Memory contents are left unchanged.
  - `pop` only, empty: `sp` stays 0, `underflow <= 1`.
  - Neither asserted: hold.
- `clearErr` clears both sticky flags at the edge. If an overflow or underflow event occurs in the same cycle, the set wins and that flag reads 1 afterwards.
- `push`/`pop` are level-sampled every edge. A strobe held for N cycles performs N operations; the controller guarantees one-cycle strobes.
- No wrap-around: `sp` saturates at 0 and at DEPTH.

## Timing
- Reset (`init_signal` low, asynchronous assert):
  - `sp = 0`, `overflow = 0`, `underflow = 0`.
  - Resulting outputs: `topData = 0`, `count = 0`, `empty = 1`, `full = 0`.
  - Memory array is not reset; its contents are unobservable while empty.
- Reset deassertion is synchronous to `clock` in the surrounding design. The first operation is accepted at the first rising edge with `init_signal` high.
- Reset asserted mid-operation: all state clears immediately, independent of `clock`. An operation strobed in that cycle is discarded.
- Push latency: 1 cycle. The value pushed at edge k appears on `topData` after edge k.
- Pop/return: `topData` is valid during the return cycle, before the edge. The PC captures it at the same edge that decrements `sp`. After that edge, `topData` shows the next-older entry.
- `count`, `empty`, `full` and the flags change only at clock edges or at reset.
- Back-to-back operations on consecutive cycles are supported with no bubbles.

## Test plan
- Reset: hold `init_signal` = 0 with `push` = 1 and `pushData` = 0x123 over 2 edges → `count` = 0, `empty` = 1, `topData` = 0x000, both flags 0.
- LIFO order: push 0x010, 0x020, 0x030 on consecutive cycles.
  - After the pushes: `topData` = 0x030, `count` = 3.
  - Then pop ×3, checking `topData` before each edge: 0x030, 0x020, 0x010.
  - Finally: `empty` = 1, `topData` = 0.
- Full/overflow: push 0x100..0x107 (8 pushes) → `full` = 1, `topData` = 0x107. Push 0xFFF → `count` stays 8, `topData` stays 0x107, `overflow` = 1. Pop once → `topData` = 0x106, `overflow` stays 1.
- Underflow and clear: from empty, pop → `underflow` = 1, `count` = 0. Next cycle assert `clearErr` with a pop → `underflow` stays 1 (set wins). Next cycle `clearErr` alone → `underflow` = 0.
- Simultaneous push+pop:
  - With stack [0x0AA, 0x0BB], assert both with `pushData` = 0x0CC → `count` = 2, `topData` = 0x0CC. Pop → `topData` = 0x0AA.
  - From empty, assert both with `pushData` = 0x055 → `count` = 1, `topData` = 0x055, `underflow` = 0.
- Mid-operation reset: push 0x011, 0x022, then pull `init_signal` low between edges → `count`, `topData`, `empty` update without a clock edge (0, 0, 1). After release, push 0x033 → `topData` = 0x033, `count` = 1.
